// File: rtl/frame_filter_pkg.sv
// Shared types and constants for the frame colour filter pipeline.
// Optional ordered dither helper is used only when FRAME_COLOR_FILTER_DITHER_EN is defined.
package frame_filter_pkg;

  typedef enum logic [1:0] {
    FM_PASS   = 2'd0,
    FM_GRAY   = 2'd1,
    FM_INVERT = 2'd2,
    FM_ROTATE = 2'd3
  } filter_mode_t;

  localparam logic [7:0] LUMA_R = 8'd77;
  localparam logic [7:0] LUMA_G = 8'd150;
  localparam logic [7:0] LUMA_B = 8'd29;

  typedef struct packed {
    logic [5:0] r;
    logic [5:0] g;
    logic [5:0] b;
  } rgb18_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  // Indexed by {y[0], x[0]}
  localparam logic [1:0] BAYER2X2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  function automatic logic [3:0] dither_chan(input logic [5:0] c, input logic [1:0] t);
    logic [6:0] s;
    s = {1'b0, c} + {5'b0, t};
    return (s > 7'd63) ? 4'hF : 4'(s >> 2);
  endfunction

endpackage

// File: rtl/color_op.sv
// Combinational per-pixel colour transform on 6-bit channels (filter stage).
// Zero latency; no flow control, the parent registers the result.
module color_op
  import frame_filter_pkg::*;
(
  input  filter_mode_t mode_i,
  input  rgb18_t       pix_i,
  output rgb18_t       pix_o
);

  logic [13:0] acc;
  logic [5:0]  luma;

  // 77+150+29 = 256, so 63*256 fits 14 bits and luma never exceeds 63
  always_comb begin
    acc  = 14'(LUMA_R) * 14'(pix_i.r) + 14'(LUMA_G) * 14'(pix_i.g) + 14'(LUMA_B) * 14'(pix_i.b);
    luma = 6'(acc >> 8);
  end

  always_comb begin
    pix_o = pix_i;
    case (mode_i)
      FM_PASS:   pix_o = pix_i;
      FM_GRAY:   pix_o = '{r: luma, g: luma, b: luma};
      FM_INVERT: pix_o = '{r: 6'd63 - pix_i.r, g: 6'd63 - pix_i.g, b: 6'd63 - pix_i.b};
      FM_ROTATE: pix_o = '{r: pix_i.g, g: pix_i.b, b: pix_i.r};
      default:   pix_o = pix_i;
    endcase
  end

endmodule

// File: rtl/frame_color_filter.sv
// Colour filter between picture BRAM and VGA pins; 3 pixel_ce-qualified stages, all state holds when pixel_ce=0.
// Ordered 2x2 dither on picture pixels is enabled by defining FRAME_COLOR_FILTER_DITHER_EN.
module frame_color_filter
  import frame_filter_pkg::*;
#(
  parameter int unsigned H_SIZE     = 607,
  parameter int unsigned V_SIZE     = 455,
  parameter logic [11:0] BORDER_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_ce,
  input  logic        loaded,
  input  logic [1:0]  mode_sw,
  input  logic [17:0] raw_rgb,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        de_in,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [1:0]  active_mode
);

  localparam logic [9:0] H_LIM = 10'(H_SIZE);
  localparam logic [9:0] V_LIM = 10'(V_SIZE);

  filter_mode_t mode_q, mode_d;

  rgb18_t s1_pix_q;
  logic   s1_hs_q, s1_vs_q, s1_de_q, s1_pic_q;
  rgb18_t s2_pix_q, s2_pix_d;
  logic   s2_hs_q, s2_vs_q, s2_de_q, s2_pic_q;
  rgb12_t out_q, out_d;
  logic   hs_q, vs_q, de_q;

  // Latching at frame start means the frame-start pixel itself sees the new mode in the filter stage
  always_comb begin
    mode_d = mode_q;
    if (pixel_ce && (x == 10'd0) && (y == 10'd0)) mode_d = filter_mode_t'(mode_sw);
  end

  color_op u_color_op (
    .mode_i (mode_q),
    .pix_i  (s1_pix_q),
    .pix_o  (s2_pix_d)
  );

`ifdef FRAME_COLOR_FILTER_DITHER_EN
  logic [1:0] s1_ph_q, s2_ph_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_ph_q <= '0;
      s2_ph_q <= '0;
    end else if (pixel_ce) begin
      s1_ph_q <= {y[0], x[0]};
      s2_ph_q <= s1_ph_q;
    end
  end
`endif

  always_comb begin
    out_d = '0;
    if (s2_de_q) begin
      if (!s2_pic_q) begin
        out_d = BORDER_RGB;
      end else begin
`ifdef FRAME_COLOR_FILTER_DITHER_EN
        out_d.r = dither_chan(s2_pix_q.r, BAYER2X2[s2_ph_q]);
        out_d.g = dither_chan(s2_pix_q.g, BAYER2X2[s2_ph_q]);
        out_d.b = dither_chan(s2_pix_q.b, BAYER2X2[s2_ph_q]);
`else
        out_d.r = 4'(s2_pix_q.r >> 2);
        out_d.g = 4'(s2_pix_q.g >> 2);
        out_d.b = 4'(s2_pix_q.b >> 2);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q   <= FM_PASS;
      s1_pix_q <= '0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_de_q  <= 1'b0;
      s1_pic_q <= 1'b0;
      s2_pix_q <= '0;
      s2_hs_q  <= 1'b1;
      s2_vs_q  <= 1'b1;
      s2_de_q  <= 1'b0;
      s2_pic_q <= 1'b0;
      out_q    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      de_q     <= 1'b0;
    end else begin
      mode_q <= mode_d;
      if (pixel_ce) begin
        s1_pix_q <= raw_rgb;
        s1_hs_q  <= hsync_in;
        s1_vs_q  <= vsync_in;
        s1_de_q  <= de_in;
        s1_pic_q <= loaded && (x < H_LIM) && (y < V_LIM);
        s2_pix_q <= s2_pix_d;
        s2_hs_q  <= s1_hs_q;
        s2_vs_q  <= s1_vs_q;
        s2_de_q  <= s1_de_q;
        s2_pic_q <= s1_pic_q;
        out_q    <= out_d;
        hs_q     <= s2_hs_q;
        vs_q     <= s2_vs_q;
        de_q     <= s2_de_q;
      end
    end
  end

  assign vga_r       = out_q.r;
  assign vga_g       = out_q.g;
  assign vga_b       = out_q.b;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign de_out      = de_q;
  assign active_mode = mode_q;

endmodule

// File: tb/tb_frame_color_filter.sv
// Bench for frame_color_filter: directed scenarios plus randomized traffic against a spec-level model.
module tb_frame_color_filter;

`ifdef FRAME_COLOR_FILTER_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif
  localparam logic [11:0] BRGB = 12'h00F;
  localparam logic [14:0] RST  = {12'h000, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset, pixel_ce, loaded;
  logic [1:0]  mode_sw;
  logic [17:0] raw_rgb;
  logic [9:0]  x, y;
  logic hsync_in, vsync_in, de_in;
  logic [3:0] vga_r, vga_g, vga_b;
  logic hsync_out, vsync_out, de_out;
  logic [1:0] active_mode;

  always #5 clk = ~clk;

  frame_color_filter #(.H_SIZE(607), .V_SIZE(455), .BORDER_RGB(BRGB)) dut (
    .clk(clk), .reset(reset), .pixel_ce(pixel_ce), .loaded(loaded), .mode_sw(mode_sw),
    .raw_rgb(raw_rgb), .x(x), .y(y), .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .de_out(de_out), .active_mode(active_mode)
  );

  int tests = 0;
  int fails = 0;
  logic [14:0] pipe[$];
  int          m_mode = 0;
  logic [14:0] exp_out = RST;
  logic [16:0] exp_all, obs;

  assign obs = {vga_r, vga_g, vga_b, hsync_out, vsync_out, de_out, active_mode};

  function automatic int chan_out(int c, int t);
    int v;
    v = c + (DITHER ? t : 0);
    if (v > 63) v = 63;
    return v / 4;
  endfunction

  function automatic logic [11:0] model_rgb(logic [17:0] px, int md, bit pic, bit de, int x0, int y0);
    int bay[4];
    int r, g, b, rr, gg, bb, lum, t;
    bay = '{0, 2, 3, 1};
    if (!de) return 12'h000;
    if (!pic) return BRGB;
    r = int'(px[17:12]); g = int'(px[11:6]); b = int'(px[5:0]);
    rr = r; gg = g; bb = b;
    case (md)
      1: begin lum = (77 * r + 150 * g + 29 * b) / 256; rr = lum; gg = lum; bb = lum; end
      2: begin rr = 63 - r; gg = 63 - g; bb = 63 - b; end
      3: begin rr = g; gg = b; bb = r; end
      default: ;
    endcase
    t = bay[y0 * 2 + x0];
    return {4'(chan_out(rr, t)), 4'(chan_out(gg, t)), 4'(chan_out(bb, t))};
  endfunction

  // Advance one clock, update the reference model from the inputs sampled at that edge
  task automatic tick();
    bit pic;
    @(posedge clk);
    if (reset) begin
      pipe = {RST, RST};
      m_mode = 0;
      exp_out = RST;
    end else if (pixel_ce) begin
      if (x == 10'd0 && y == 10'd0) m_mode = int'(mode_sw);
      pic = loaded && (x < 10'd607) && (y < 10'd455);
      pipe.push_back({model_rgb(raw_rgb, m_mode, pic, de_in, int'(x[0]), int'(y[0])),
                      hsync_in, vsync_in, de_in});
      exp_out = pipe.pop_front();
    end
    exp_all = {exp_out, 2'(m_mode)};
    #1;
  endtask

  task automatic drive(input int xi, input int yi, input logic [17:0] rgb, input logic de);
    x = 10'(xi);
    y = 10'(yi);
    raw_rgb = rgb;
    de_in = de;
    hsync_in = 1'($urandom);
    vsync_in = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1; pixel_ce = 1'b1; loaded = 1'b1; mode_sw = 2'd3;
    drive(0, 0, 18'h3FFFF, 1'b1);
    tick(); tick();
    tests++;
    if (obs !== {RST, 2'b00}) begin
      fails++; $display("FAIL reset_state got %h want %h", obs, {RST, 2'b00});
    end
    reset = 1'b0;
    drive(3, 3, 18'h0, 1'b0);
    tick();
    tests++;
    if (obs !== exp_all) begin
      fails++; $display("FAIL reset_release got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_passthrough();
    mode_sw = 2'd0;
    drive(0, 0, 18'h0, 1'b1); tick();
    drive(10, 10, 18'h3F000, 1'b1); tick();
    drive(11, 10, 18'h00FFF, 1'b1); tick();
    tick();
    tests++;
    if ({vga_r, vga_g, vga_b, de_out} !== {12'hF00, 1'b1}) begin
      fails++; $display("FAIL passthrough got %h de %b want F00 de 1", {vga_r, vga_g, vga_b}, de_out);
    end
    tests++;
    if (obs !== exp_all) begin
      fails++; $display("FAIL passthrough_model got %h want %h", obs, exp_all);
    end
  endtask

  task automatic test_gray();
    mode_sw = 2'd1;
    drive(0, 0, {6'd63, 6'd63, 6'd63}, 1'b1); tick();
    drive(1, 0, {6'd32, 6'd0, 6'd0}, 1'b1); tick();
    drive(2, 0, 18'h0, 1'b1); tick();
    tests++;
    if ({vga_r, vga_g, vga_b, active_mode} !== {12'hFFF, 2'd1}) begin
      fails++; $display("FAIL gray_white got %h mode %0d want FFF mode 1", {vga_r, vga_g, vga_b}, active_mode);
    end
    tick();
    tests++;
    if ({vga_r, vga_g, vga_b} !== 12'h222) begin
      fails++; $display("FAIL gray_red got %h want 222", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_border();
    int xs[5], ys[5];
    logic ld[5], de[5];
    logic [11:0] ev[5];
    xs = '{607, 606, 5, 5, 5};
    ys = '{5, 5, 455, 5, 5};
    ld = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    de = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ev = '{12'h00F, 12'hFFF, 12'h00F, 12'h00F, 12'h000};
    for (int i = 0; i < 7; i++) begin
      if (i < 5) begin
        loaded = ld[i];
        drive(xs[i], ys[i], 18'h3FFFF, de[i]);
      end else begin
        loaded = 1'b1;
        drive(20, 5, 18'h0, 1'b1);
      end
      tick();
      if (i >= 2) begin
        tests++;
        if ({vga_r, vga_g, vga_b} !== ev[i - 2]) begin
          fails++; $display("FAIL border_%0d got %h want %h", i - 2, {vga_r, vga_g, vga_b}, ev[i - 2]);
        end
      end
    end
  endtask

  task automatic test_mode_timing();
    mode_sw = 2'd0;
    drive(0, 0, 18'h0, 1'b1); tick();
    mode_sw = 2'd1;
    for (int i = 0; i < 4; i++) begin
      drive(100 + i, 50, 18'($urandom), 1'b1); tick();
      tests++;
      if (active_mode !== 2'd0) begin
        fails++; $display("FAIL mode_midframe got %0d want 0", active_mode);
      end
    end
    mode_sw = 2'd2;
    drive(0, 0, 18'h3F000, 1'b1); tick();
    tests++;
    if (active_mode !== 2'd2) begin
      fails++; $display("FAIL mode_framestart got %0d want 2", active_mode);
    end
    drive(1, 0, 18'h0, 1'b1); tick();
    tick();
    tests++;
    if ({vga_r, vga_g, vga_b} !== 12'h0FF) begin
      fails++; $display("FAIL mode_first_pixel got %h want 0FF", {vga_r, vga_g, vga_b});
    end
  endtask

  task automatic test_stall();
    bit pat[5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 25; i++) begin
      pixel_ce = pat[i % 5];
      drive(200 + i, 40, 18'($urandom), 1'($urandom));
      tick();
      tests++;
      if (obs !== exp_all) begin
        fails++; $display("FAIL stall_%0d got %h want %h", i, obs, exp_all);
      end
    end
    pixel_ce = 1'b1;
  endtask

  task automatic test_reset_mid();
    mode_sw = 2'd3;
    drive(0, 0, 18'h0, 1'b1); tick();
    drive(300, 200, 18'h3F000, 1'b1); tick();
    drive(301, 200, 18'h00FC0, 1'b1); tick();
    tests++;
    if (active_mode !== 2'd3) begin
      fails++; $display("FAIL rst_mid_premode got %0d want 3", active_mode);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++;
    if (obs !== {RST, 2'b00}) begin
      fails++; $display("FAIL rst_mid_outputs got %h want %h", obs, {RST, 2'b00});
    end
    mode_sw = 2'd1;
    for (int i = 0; i < 4; i++) begin
      drive(302 + i, 200, 18'($urandom), 1'b1); tick();
      tests++;
      if (obs !== exp_all || active_mode !== 2'd0) begin
        fails++; $display("FAIL rst_mid_refill_%0d got %h want %h", i, obs, exp_all);
      end
    end
    drive(0, 0, 18'h0, 1'b1); tick();
    tests++;
    if (active_mode !== 2'd1) begin
      fails++; $display("FAIL rst_mid_relatch got %0d want 1", active_mode);
    end
  endtask

  task automatic test_dither();
    int xs[7], ys[7];
    logic [5:0] rv[7];
    logic [11:0] ev[7];
    xs = '{0, 1, 0, 1, 0, 0, 607};
    ys = '{0, 0, 0, 1, 0, 1, 0};
    rv = '{6'd62, 6'd62, 6'd61, 6'd60, 6'd59, 6'd57, 6'd63};
    ev = '{12'hF00, 12'hF00, 12'hF00, 12'hF00, 12'hE00, (DITHER ? 12'hF00 : 12'hE00), 12'h00F};
    mode_sw = 2'd0;
    loaded = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) drive(xs[i], ys[i], {rv[i], 12'h000}, 1'b1);
      else drive(30, 3, 18'h0, 1'b1);
      tick();
      if (i >= 2) begin
        tests++;
        if ({vga_r, vga_g, vga_b} !== ev[i - 2]) begin
          fails++; $display("FAIL dither_%0d got %h want %h", i - 2, {vga_r, vga_g, vga_b}, ev[i - 2]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      pixel_ce = ($urandom_range(0, 3) != 0);
      loaded = ($urandom_range(0, 9) != 0);
      mode_sw = 2'($urandom);
      if ($urandom_range(0, 11) == 0) drive(0, 0, 18'($urandom), 1'($urandom));
      else drive($urandom_range(598, 616), $urandom_range(0, 460), 18'($urandom), 1'($urandom));
      tick();
      tests++;
      if (obs !== exp_all) begin
        fails++; $display("FAIL random_%0d got %h want %h", i, obs, exp_all);
      end
    end
    reset = 1'b0;
    pixel_ce = 1'b1;
    loaded = 1'b1;
  endtask

  initial begin
    reset = 1'b1; pixel_ce = 1'b0; loaded = 1'b0; mode_sw = 2'd0;
    raw_rgb = '0; x = '0; y = '0; hsync_in = 1'b1; vsync_in = 1'b1; de_in = 1'b0;
    test_reset();
    test_passthrough();
    test_gray();
    test_border();
    test_mode_timing();
    test_stall();
    test_reset_mid();
    test_dither();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_color_filter.md
Name: frame_color_filter

Overview:
- Downstream consumer of the picture memory's raw 18-bit pixel stream; sits between the BRAM read side and the VGA pins.
- Applies a selectable colour filter: passthrough, grayscale, invert or channel rotate.
- Reduces 6-bit channels to 4-bit VGA DAC width and delay-aligns syncs and data-enable with the filtered pixel.
- Three-stage pipeline, advanced only on pixel clock-enable cycles.

Parameters:
- H_SIZE, 607, stored picture width in pixels; x >= H_SIZE is border.
- V_SIZE, 455, stored picture height in lines; y >= V_SIZE is border.
- BORDER_RGB, 12'h000, 12-bit colour driven for border pixels while de_in=1.

Ports:
- clk  in  1  base clock; the only clock in the block.
- reset  in  1  synchronous, active-high reset.
- pixel_ce  in  1  pixel-rate clock enable; the pipeline advances only when 1.
- loaded  in  1  picture-stored flag; while 0, the picture area is driven as border.
- mode_sw  in  2  requested filter: 0 passthrough, 1 grayscale, 2 invert, 3 rotate.
- raw_rgb  in  18  {R[17:12],G[11:6],B[5:0]}, aligned with x/y/syncs on the same ce cycle.
- x  in  10  horizontal count of the current pixel.
- y  in  10  vertical count of the current pixel.
- hsync_in  in  1  active-low horizontal sync.
- vsync_in  in  1  active-low vertical sync.
- de_in  in  1  visible-area data enable.
- vga_r  out  4  filtered red.
- vga_g  out  4  filtered green.
- vga_b  out  4  filtered blue.
- hsync_out  out  1  hsync_in delayed by 3 ce cycles.
- vsync_out  out  1  vsync_in delayed by 3 ce cycles.
- de_out  out  1  de_in delayed by 3 ce cycles.
- active_mode  out  2  filter mode currently applied.

Behaviour:
- Clocking and reset: single clock clk, synchronous active-high reset; nothing is asynchronous.
- Reset values:
  - vga_r/g/b = 0, de_out = 0.
  - hsync_out = 1, vsync_out = 1 (inactive).
  - active_mode = 0.
  - All pipeline registers cleared: valid flags 0, syncs 1.
- Stall: with pixel_ce=0 every register holds. Latency is exactly 3 ce-qualified cycles from input to output, for all modes and both options.
- S1 (capture): register raw_rgb, the syncs, de_in, x[0], y[0], and in_pic = loaded & (x<H_SIZE) & (y<V_SIZE).
- S2 (filter), channels 6-bit:
  - Mode 0: unchanged.
  - Mode 1: Y = (77*R + 150*G + 29*B) >> 8, with a 14-bit unsigned accumulator; maximum Y = 63, no overflow. R = G = B = Y.
  - Mode 2: each channel becomes 63 - c.
  - Mode 3: (R,G,B) becomes (G,B,R).
- S3 (output):
  - If !de: rgb = 0.
  - Else if !in_pic: rgb = BORDER_RGB.
  - Else: each channel = c[5:2].
- Mode latch:
  - mode_sw is sampled into active_mode only on a ce cycle where x==0 and y==0, i.e. at frame start. No mid-frame tearing.
  - A mode_sw change at any other time takes effect at the next frame start.
  - mode_sw changing on the frame-start cycle itself takes the new value.
  - active_mode is applied at S2 for the pixel captured on the same cycle it updates, and for all later pixels.
- loaded falling mid-frame: affected pixels become border from the next captured pixel onward; no flush.
- Reset mid-frame:
  - Outputs return to reset values on the next edge.
  - Pipeline refills over 3 ce cycles.
  - active_mode stays 0 until the next x==0,y==0.
- Boundaries:
  - x = H_SIZE-1 is picture; x = H_SIZE is border.
  - Same rule for y with V_SIZE.
  - Counts beyond 1023 are not possible (10-bit inputs).

Optional Feature:
- Macro: FRAME_COLOR_FILTER_DITHER_EN.
- Defined (ordered dither): in S3, before truncation, add t = Bayer2x2[{y[0],x[0]}] to each channel.
  - Matrix: {0,0}→0, {0,1}→2, {1,0}→3, {1,1}→1.
  - Saturate the sum at 63, then take [5:2].
  - Dither applies to picture pixels only, never to border.
- Undefined: plain truncation c[5:2]; no dither logic synthesised.
- Latency is identical in both builds.

Decomposition:
- Package frame_filter_pkg:
  - enum filter_mode_t {FM_PASS, FM_GRAY, FM_INVERT, FM_ROTATE}.
  - Luma constants LUMA_R=77, LUMA_G=150, LUMA_B=29.
  - Typedefs rgb18_t and rgb12_t.
  - 2x2 Bayer constant array.
- Sub-module: color_op, combinational, one S2 channel transform (mode, R, G, B → R', G', B'). Instantiated once, registered by the parent.

Test Plan:
- Passthrough: mode 0, loaded=1, raw_rgb=18'h3F_000 (R=63, G=0, B=0) at x=10, y=10, de=1 → after 3 ce cycles vga = F/0/0, de_out=1.
- Grayscale: mode 1 latched at x=0,y=0; R=G=B=63 → Y=63, vga = F/F/F. R=32, G=0, B=0 → Y=9, vga = 2/2/2.
- Border and mode timing:
  - x=607, y=5, de=1, BORDER_RGB=12'h00F → vga = 0/0/F.
  - mode_sw changes 0→2 at x=100,y=50 → active_mode stays 0 until the next frame start, then 2.
- Stall: toggle pixel_ce 1,0,0,1,1 with distinct pixels → outputs update only on ce=1 edges; hsync/vsync/de stay aligned with their pixel (3 ce latency).
- Reset mid-frame at x=300,y=200 with mode 3 active → next cycle rgb=0, syncs=1, de_out=0, active_mode=0; mode re-latched at the next x=0,y=0.
- DITHER_EN build: R=62 at x=1, y=0 → 62+2 saturates to 63 → vga_r=F. Same pixel at x=0, y=0 → 62 → vga_r=F. R=61 at x=0, y=0 → vga_r=F. R=60 at x=1, y=1 → 61 → vga_r=F. R=59 at x=0, y=0 → vga_r=E.
